// File: rtl/imem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_arbiter_pkg
// Shared constants and helpers for the instruction-memory read arbiter.
//   IMEM_BASE / IMEM_LIMIT : default legal byte-address window (inclusive)
//   imem_port_e            : port-select encoding, F = 0, D = 1
//   addr_legal()           : range + word-alignment check, unsigned compare
// ---------------------------------------------------------------------------
package imem_arbiter_pkg;

  localparam logic [31:0] IMEM_BASE  = 32'h0100_0000;
  localparam logic [31:0] IMEM_LIMIT = 32'h0100_07FF;

  typedef enum logic {
    IMEM_PORT_F = 1'b0,
    IMEM_PORT_D = 1'b1
  } imem_port_e;

  // An address may be read only if it lies in [base, limit] and is word aligned.
  function automatic logic addr_legal(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] limit);
    return (addr >= base) && (addr <= limit) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// ---------------------------------------------------------------------------
// imem_arbiter_if
// Bundles the two requester channels (fetch F, debug D) and the instruction
// memory read port seen by imem_arbiter.
//   f_* / d_* : req_valid, req_ready, req_addr, rsp_valid, rsp_ready,
//               rsp_data, rsp_err for each requester
//   mem_*     : mem_rd, mem_addr (to instruction_mem), mem_data (from it)
// Modports:
//   slave  : the arbiter's view
//   master : the requesters' and memory's view
// ---------------------------------------------------------------------------
interface imem_arbiter_if;

  logic        f_req_valid;
  logic        f_req_ready;
  logic [31:0] f_req_addr;
  logic        f_rsp_valid;
  logic        f_rsp_ready;
  logic [31:0] f_rsp_data;
  logic        f_rsp_err;

  logic        d_req_valid;
  logic        d_req_ready;
  logic [31:0] d_req_addr;
  logic        d_rsp_valid;
  logic        d_rsp_ready;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_data;

  modport slave (
    input  f_req_valid, f_req_addr, f_rsp_ready,
    output f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    input  d_req_valid, d_req_addr, d_rsp_ready,
    output d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    output mem_rd, mem_addr,
    input  mem_data
  );

  modport master (
    output f_req_valid, f_req_addr, f_rsp_ready,
    input  f_req_ready, f_rsp_valid, f_rsp_data, f_rsp_err,
    output d_req_valid, d_req_addr, d_rsp_ready,
    input  d_req_ready, d_rsp_valid, d_rsp_data, d_rsp_err,
    input  mem_rd, mem_addr,
    output mem_data
  );

endinterface

// File: rtl/imem_arbiter_rsp_slot.sv
// ---------------------------------------------------------------------------
// imem_rsp_slot
// Response slot for one arbiter port. Tracks the read issued last cycle,
// passes memory data straight through when the consumer is ready, and
// otherwise freezes the response in a hold register so a later read by the
// other port cannot corrupt it.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   grant_i        : this port was granted in the current cycle
//   legal_i        : the granted address passed the range/alignment check
//   rsp_ready_i    : consumer ready
//   mem_data_i     : instruction memory read data
//   inflight_o     : a memory read for this port is returning this cycle
//   rsp_valid_o    : response valid
//   rsp_data_o     : response data (0 on error or when idle)
//   rsp_err_o      : response error flag
// ---------------------------------------------------------------------------
module imem_rsp_slot (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant_i,
  input  logic        legal_i,
  input  logic        rsp_ready_i,
  input  logic [31:0] mem_data_i,
  output logic        inflight_o,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_data_o,
  output logic        rsp_err_o
);

  logic        inflight_q,    inflight_d;
  logic        err_pending_q, err_pending_d;
  logic        hold_valid_q,  hold_valid_d;
  logic [31:0] hold_data_q,   hold_data_d;
  logic        hold_err_q,    hold_err_d;

  // Output mux and next state. A fresh response (inflight/err_pending) and a
  // held response are mutually exclusive: a port is only granted when its
  // slot empties in that same cycle.
  always_comb begin
    rsp_valid_o   = 1'b0;
    rsp_data_o    = '0;
    rsp_err_o     = 1'b0;
    inflight_d    = grant_i & legal_i;
    err_pending_d = grant_i & ~legal_i;
    hold_valid_d  = hold_valid_q;
    hold_data_d   = hold_data_q;
    hold_err_d    = hold_err_q;

    if (hold_valid_q) begin
      rsp_valid_o = 1'b1;
      rsp_data_o  = hold_data_q;
      rsp_err_o   = hold_err_q;
    end else if (inflight_q) begin
      rsp_valid_o = 1'b1;
      rsp_data_o  = mem_data_i;
    end else if (err_pending_q) begin
      rsp_valid_o = 1'b1;
      rsp_err_o   = 1'b1;
    end

    // Freeze a fresh response the consumer did not take; release the hold
    // once it is accepted.
    if ((inflight_q || err_pending_q) && !hold_valid_q && !rsp_ready_i) begin
      hold_valid_d = 1'b1;
      hold_data_d  = rsp_data_o;
      hold_err_d   = rsp_err_o;
    end else if (hold_valid_q && rsp_ready_i) begin
      hold_valid_d = 1'b0;
    end
  end

  // Slot state registers; reset discards any in-flight or held response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      err_pending_q <= 1'b0;
      hold_valid_q  <= 1'b0;
      hold_data_q   <= '0;
      hold_err_q    <= 1'b0;
    end else begin
      inflight_q    <= inflight_d;
      err_pending_q <= err_pending_d;
      hold_valid_q  <= hold_valid_d;
      hold_data_q   <= hold_data_d;
      hold_err_q    <= hold_err_d;
    end
  end

  assign inflight_o = inflight_q;

endmodule

// File: rtl/imem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_arbiter
// Shares the synchronous read port of instruction_mem between the fetch
// unit (F) and the debug/loader path (D). At most one request is granted per
// cycle; legal addresses issue a memory read, illegal ones produce an error
// response one cycle later without touching memory.
// Parameters:
//   BASE_ADDR, LIMIT_ADDR : inclusive legal byte-address window
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_arbiter_if.slave (F/D request+response, memory port)
// Build option:
//   IMEM_ARB_DBG_PRIO_EN defined   -> D always wins a tie (fixed priority)
//   IMEM_ARB_DBG_PRIO_EN undefined -> round-robin on ties using last grant
// ---------------------------------------------------------------------------
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = IMEM_BASE,
  parameter logic [31:0] LIMIT_ADDR = IMEM_LIMIT
) (
  input logic           clk,
  input logic           rst_n,
  imem_arbiter_if.slave bus
);

  logic        f_inflight, d_inflight;
  logic        f_rsp_valid, d_rsp_valid;
  logic        f_elig, d_elig;
  logic        grant_f, grant_d, any_grant;
  logic [31:0] sel_addr;
  logic        sel_legal;
  logic [31:0] mem_addr_q, mem_addr_d;

`ifndef IMEM_ARB_DBG_PRIO_EN
  imem_port_e  last_grant_q, last_grant_d;
`endif

  // A port may be granted when it requests, its response slot empties by the
  // end of this cycle, and no read of its own is returning right now.
  assign f_elig = bus.f_req_valid & (~f_rsp_valid | bus.f_rsp_ready) & ~f_inflight;
  assign d_elig = bus.d_req_valid & (~d_rsp_valid | bus.d_rsp_ready) & ~d_inflight;

  // Arbitration: a lone eligible port wins; a tie is broken by the build
  // option. Everything is held off while reset is asserted.
  always_comb begin
    grant_f = 1'b0;
    grant_d = 1'b0;
    if (f_elig && d_elig) begin
`ifdef IMEM_ARB_DBG_PRIO_EN
      grant_d = 1'b1;
`else
      if (last_grant_q == IMEM_PORT_F) grant_d = 1'b1;
      else                             grant_f = 1'b1;
`endif
    end else begin
      grant_f = f_elig;
      grant_d = d_elig;
    end
    if (!rst_n) begin
      grant_f = 1'b0;
      grant_d = 1'b0;
    end
  end

  assign any_grant = grant_f | grant_d;
  assign sel_addr  = grant_d ? bus.d_req_addr : bus.f_req_addr;
  assign sel_legal = addr_legal(sel_addr, BASE_ADDR, LIMIT_ADDR);

  // Memory address follows the granted request and otherwise holds the last
  // address presented.
  always_comb begin
    mem_addr_d = mem_addr_q;
    if (any_grant) mem_addr_d = sel_addr;
  end

  assign bus.mem_rd      = any_grant & sel_legal;
  assign bus.mem_addr    = mem_addr_d;
  assign bus.f_req_ready = grant_f;
  assign bus.d_req_ready = grant_d;

`ifndef IMEM_ARB_DBG_PRIO_EN
  // Remember who won last so the other port wins the next tie.
  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_f)      last_grant_d = IMEM_PORT_F;
    else if (grant_d) last_grant_d = IMEM_PORT_D;
  end

  // Starting from D means F wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_q <= IMEM_PORT_D;
    else        last_grant_q <= last_grant_d;
  end
`endif

  // Last-issued memory address register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_addr_q <= '0;
    else        mem_addr_q <= mem_addr_d;
  end

  imem_rsp_slot u_slot_f (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_i     (grant_f),
    .legal_i     (sel_legal),
    .rsp_ready_i (bus.f_rsp_ready),
    .mem_data_i  (bus.mem_data),
    .inflight_o  (f_inflight),
    .rsp_valid_o (f_rsp_valid),
    .rsp_data_o  (bus.f_rsp_data),
    .rsp_err_o   (bus.f_rsp_err)
  );

  imem_rsp_slot u_slot_d (
    .clk         (clk),
    .rst_n       (rst_n),
    .grant_i     (grant_d),
    .legal_i     (sel_legal),
    .rsp_ready_i (bus.d_rsp_ready),
    .mem_data_i  (bus.mem_data),
    .inflight_o  (d_inflight),
    .rsp_valid_o (d_rsp_valid),
    .rsp_data_o  (bus.d_rsp_data),
    .rsp_err_o   (bus.d_rsp_err)
  );

  assign bus.f_rsp_valid = f_rsp_valid;
  assign bus.d_rsp_valid = d_rsp_valid;

endmodule

// File: tb/tb_imem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_arbiter
// Scoreboard bench for imem_arbiter. Each cycle the bench states which port
// it expects to be granted; the expected {err,data} of every grant is queued
// per port and compared against the response whenever it is valid.
// ---------------------------------------------------------------------------
module tb_imem_arbiter;

`ifdef IMEM_ARB_DBG_PRIO_EN
  localparam logic PRIO = 1'b1;
`else
  localparam logic PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  imem_arbiter_if bus ();

  imem_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checkCount = 0;
  int passCount  = 0;

  logic [32:0] fQ[$];
  logic [32:0] dQ[$];

  // Contents of the modelled instruction memory: a distinct word per address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic tbLegal(input logic [31:0] a);
    return (a >= 32'h0100_0000) && (a <= 32'h0100_07FF) && (a[1:0] == 2'b00);
  endfunction

  // Synchronous memory model; garbage when not read so stale pass-through shows.
  always @(posedge clk)
    bus.mem_data <= bus.mem_rd ? memWord(bus.mem_addr) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
  endtask

  // One cycle: drive at negedge, then compare responses, grants and memory port.
  task automatic applyStimulus(input logic fv, input logic [31:0] fa, input logic frr,
                               input logic dv, input logic [31:0] da, input logic drr,
                               input logic expF, input logic expD);
    logic expRd;
    @(negedge clk);
    bus.f_req_valid = fv;  bus.f_req_addr = fa;  bus.f_rsp_ready = frr;
    bus.d_req_valid = dv;  bus.d_req_addr = da;  bus.d_rsp_ready = drr;
    #1;
    checkOutput("f_rsp_valid", bus.f_rsp_valid, fQ.size() != 0);
    if (bus.f_rsp_valid && fQ.size() != 0) begin
      checkOutput("f_rsp_data", bus.f_rsp_data, fQ[0][31:0]);
      checkOutput("f_rsp_err", bus.f_rsp_err, fQ[0][32]);
      if (frr) void'(fQ.pop_front());
    end
    checkOutput("d_rsp_valid", bus.d_rsp_valid, dQ.size() != 0);
    if (bus.d_rsp_valid && dQ.size() != 0) begin
      checkOutput("d_rsp_data", bus.d_rsp_data, dQ[0][31:0]);
      checkOutput("d_rsp_err", bus.d_rsp_err, dQ[0][32]);
      if (drr) void'(dQ.pop_front());
    end
    checkOutput("f_req_ready", bus.f_req_ready, expF);
    checkOutput("d_req_ready", bus.d_req_ready, expD);
    expRd = (expF && tbLegal(fa)) || (expD && tbLegal(da));
    checkOutput("mem_rd", bus.mem_rd, expRd);
    if (expRd) checkOutput("mem_addr", bus.mem_addr, expF ? fa : da);
    if (expF) fQ.push_back(tbLegal(fa) ? {1'b0, memWord(fa)} : {1'b1, 32'h0});
    if (expD) dQ.push_back(tbLegal(da) ? {1'b0, memWord(da)} : {1'b1, 32'h0});
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " f_req_ready"}, bus.f_req_ready, 1'b0);
    checkOutput({tag, " d_req_ready"}, bus.d_req_ready, 1'b0);
    checkOutput({tag, " mem_rd"}, bus.mem_rd, 1'b0);
    checkOutput({tag, " f_rsp_valid"}, bus.f_rsp_valid, 1'b0);
    checkOutput({tag, " d_rsp_valid"}, bus.d_rsp_valid, 1'b0);
    checkOutput({tag, " f_rsp_data"}, bus.f_rsp_data, 32'h0);
    checkOutput({tag, " d_rsp_data"}, bus.d_rsp_data, 32'h0);
    checkOutput({tag, " f_rsp_err"}, bus.f_rsp_err, 1'b0);
    checkOutput({tag, " d_rsp_err"}, bus.d_rsp_err, 1'b0);
  endtask

  initial begin
    logic [31:0] fa, da;
    int fIdx, dIdx;

    // Reset with requests pending: ready and mem_rd must stay low.
    rst_n = 1'b0;
    bus.f_req_valid = 1'b1;  bus.f_req_addr = 32'h0100_0000;  bus.f_rsp_ready = 1'b1;
    bus.d_req_valid = 1'b1;  bus.d_req_addr = 32'h0100_0400;  bus.d_rsp_ready = 1'b1;
    #2;
    checkResetOutputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.f_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;

    // Single fetch of the base address, then drain.
    applyStimulus(1, 32'h0100_0000, 1, 0, 32'h0, 1, 1, 0);
    applyStimulus(0, 32'h0,         1, 0, 32'h0, 1, 0, 0);

    // Both ports continuously requesting: grants alternate, one read per cycle.
    fIdx = 0;
    dIdx = 0;
    for (int i = 0; i < 8; i++) begin
      fa = 32'h0100_0000 + 32'(4 * fIdx);
      da = 32'h0100_0400 + 32'(4 * dIdx);
      applyStimulus(1, fa, 1, 1, da, 1, (i % 2) == 1, (i % 2) == 0);
      if ((i % 2) == 1) fIdx++;
      else              dIdx++;
    end
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0, 0);

    // Tie after a D grant: round-robin picks F, fixed priority picks D.
    applyStimulus(0, 32'h0, 1, 1, 32'h0100_0420, 1, 0, 1);
    applyStimulus(0, 32'h0, 1, 0, 32'h0,         1, 0, 0);
    applyStimulus(1, 32'h0100_0040, 1, 1, 32'h0100_0424, 1, !PRIO, PRIO);
    applyStimulus(PRIO, 32'h0100_0040, 1, !PRIO, 32'h0100_0424, 1, PRIO, !PRIO);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0, 0);

    // Illegal addresses and window boundaries.
    applyStimulus(1, 32'h0100_0800, 1, 0, 32'h0, 1, 1, 0);
    applyStimulus(1, 32'h0100_0002, 1, 0, 32'h0, 1, 1, 0);
    applyStimulus(1, 32'h0100_07FC, 1, 0, 32'h0, 1, 1, 0);
    applyStimulus(1, 32'h00FF_FFFC, 1, 0, 32'h0, 1, 0, 0);
    applyStimulus(1, 32'h00FF_FFFC, 1, 0, 32'h0, 1, 1, 0);
    applyStimulus(0, 32'h0,         1, 0, 32'h0, 1, 0, 0);

    // F response stalled for five cycles while D keeps reading memory.
    applyStimulus(1, 32'h0100_0010, 1, 0, 32'h0,         1, 1, 0);
    applyStimulus(1, 32'h0100_0014, 0, 1, 32'h0100_0200, 1, 0, 1);
    applyStimulus(1, 32'h0100_0014, 0, 1, 32'h0100_0204, 1, 0, 0);
    applyStimulus(1, 32'h0100_0014, 0, 1, 32'h0100_0204, 1, 0, 1);
    applyStimulus(1, 32'h0100_0014, 0, 1, 32'h0100_0208, 1, 0, 0);
    applyStimulus(1, 32'h0100_0014, 0, 1, 32'h0100_0208, 1, 0, 1);
    applyStimulus(1, 32'h0100_0014, 1, 1, 32'h0100_020C, 1, 1, 0);
    applyStimulus(0, 32'h0,         1, 1, 32'h0100_020C, 1, 0, 1);
    applyStimulus(0, 32'h0,         1, 0, 32'h0,         1, 0, 0);

    // Reset during an in-flight D read: outputs clear at once, nothing after.
    applyStimulus(0, 32'h0, 1, 1, 32'h0100_0100, 1, 0, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    bus.f_req_valid = 1'b1;
    bus.d_req_valid = 1'b1;
    #1;
    checkResetOutputs("midreset");
    fQ.delete();
    dQ.delete();
    @(negedge clk);
    rst_n = 1'b1;
    bus.f_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0, 0);

    // First tie after reset: F wins under round-robin, D under fixed priority.
    applyStimulus(1, 32'h0100_0060, 1, 1, 32'h0100_0460, 1, !PRIO, PRIO);
    applyStimulus(PRIO, 32'h0100_0060, 1, !PRIO, 32'h0100_0460, 1, PRIO, !PRIO);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0, 0);
    applyStimulus(0, 32'h0, 1, 0, 32'h0, 1, 0, 0);

    checkOutput("f responses drained", fQ.size(), 32'd0);
    checkOutput("d responses drained", dQ.size(), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
